regfile_sb: RTL and testbench

Parametrised register file with an integrated per-register write scoreboard for the pipelined core. It keeps the 32×32 storage behaviour the core already depends on, with these additions:
- a configurable number of read ports;
- a hardwired-zero register;
- same-cycle write-to-read bypass;
- asynchronous clear;
- per-register pending-write counters, so decode can detect RAW hazards and stall issue.

It sits between decode (issue, read) and writeback (write).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_sb.sv | 72 +++++++
 tb/tb_regfile_sb.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, types and helpers for the register file and its write scoreboard.
package regfile_pkg;

  localparam int DEFAULT_A_WIDTH = 5;
  localparam int DEFAULT_D_WIDTH = 32;
  localparam int DEFAULT_CNT_W   = 2;
  localparam int ZERO_REG        = 0;

  typedef logic [DEFAULT_A_WIDTH-1:0] reg_addr_t;
  typedef logic [DEFAULT_D_WIDTH-1:0] reg_data_t;
  typedef logic [DEFAULT_CNT_W-1:0]   cnt_t;

  // Largest pending count a CNT_W-bit counter can hold.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback, issue handshake, status.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int A_WIDTH = DEFAULT_A_WIDTH,
  parameter int D_WIDTH = DEFAULT_D_WIDTH,
  parameter int NR      = 2
) ();

  logic [NR-1:0][A_WIDTH-1:0] RA;
  logic [NR-1:0][D_WIDTH-1:0] RD;
  logic [NR-1:0]              RD_BUSY;
  logic                       WE3;
  logic [A_WIDTH-1:0]         A3;
  logic [D_WIDTH-1:0]         WD3;
  logic                       ISSUE_VALID;
  logic [A_WIDTH-1:0]         ISSUE_RD;
  logic                       ISSUE_READY;
  logic [D_WIDTH-1:0]         DBG;
  logic                       ERR_UNDERFLOW;

  modport master (
    output RA, WE3, A3, WD3, ISSUE_VALID, ISSUE_RD,
    input  RD, RD_BUSY, ISSUE_READY, DBG, ERR_UNDERFLOW
  );

  modport slave (
    input  RA, WE3, A3, WD3, ISSUE_VALID, ISSUE_RD,
    output RD, RD_BUSY, ISSUE_READY, DBG, ERR_UNDERFLOW
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: issue increments, writeback decrements,
// producing operand-busy flags, issue backpressure and a sticky underflow error.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int A_WIDTH = DEFAULT_A_WIDTH,
  parameter int NR      = 2,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR-1:0][A_WIDTH-1:0] ra,
  input  logic                       we,
  input  logic [A_WIDTH-1:0]         a3,
  input  logic                       issue_valid,
  input  logic [A_WIDTH-1:0]         issue_rd,
  output logic                       issue_ready,
  output logic [NR-1:0]              rd_busy,
  output logic                       err_underflow
);

  localparam int                 NREG = 2 ** A_WIDTH;
  localparam logic [CNT_W-1:0]   MAX  = CNT_W'(cnt_max(CNT_W));
  localparam logic [A_WIDTH-1:0] ZERO = A_WIDTH'(ZERO_REG);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec;
  logic             wr_live;

  assign wr_live = we && (a3 != ZERO);

  // A saturated destination may still issue when its writeback lands this cycle.
  assign issue_ready = !((issue_rd != ZERO) && (cnt[issue_rd] == MAX) && !(we && (a3 == issue_rd)));

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = issue_valid && issue_ready && (issue_rd == A_WIDTH'(r)) && (A_WIDTH'(r) != ZERO);
      dec[r] = we && (a3 == A_WIDTH'(r)) && (A_WIDTH'(r) != ZERO) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc[r] && !dec[r]) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (dec[r] && !inc[r]) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
      if (wr_live && (cnt[a3] == '0)) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // The last outstanding write arriving now is forwarded, so the operand is usable.
  for (genvar i = 0; i < NR; i++) begin : g_busy
    assign rd_busy[i] = (ra[i] != ZERO) && (cnt[ra[i]] != '0)
                        && !(we && (a3 == ra[i]) && (cnt[ra[i]] == CNT_W'(1)));
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with hardwired x0, same-cycle write bypass on every read port,
// a debug mirror of one register and an attached write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int A_WIDTH = DEFAULT_A_WIDTH,
  parameter int D_WIDTH = DEFAULT_D_WIDTH,
  parameter int NR      = 2,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int DBG_IDX = 10
) (
  input logic          CLK,
  input logic          RST_N,
  regfile_sb_if.slave  bus
);

  localparam int                 NREG  = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] ZERO  = A_WIDTH'(ZERO_REG);
  localparam logic [A_WIDTH-1:0] DBG_A = A_WIDTH'(DBG_IDX);

  logic [D_WIDTH-1:0] regs [NREG];
  logic               wr_live;

  assign wr_live = bus.WE3 && (bus.A3 != ZERO);

  // x0 is never written, so reading it from the array always yields zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_live) begin
      regs[bus.A3] <= bus.WD3;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_read
    logic [D_WIDTH-1:0] rd_val;
    always_comb begin
      rd_val = '0;
      if (RST_N) begin
        rd_val = (wr_live && (bus.A3 == bus.RA[i])) ? bus.WD3 : regs[bus.RA[i]];
      end
    end
    assign bus.RD[i] = rd_val;
  end

  always_comb begin
    bus.DBG = '0;
    if (RST_N && (DBG_A != ZERO)) begin
      bus.DBG = (wr_live && (bus.A3 == DBG_A)) ? bus.WD3 : regs[DBG_A];
    end
  end

  regfile_scoreboard #(
    .A_WIDTH (A_WIDTH),
    .NR      (NR),
    .CNT_W   (CNT_W)
  ) u_scoreboard (
    .clk           (CLK),
    .rst_n         (RST_N),
    .ra            (bus.RA),
    .we            (bus.WE3),
    .a3            (bus.A3),
    .issue_valid   (bus.ISSUE_VALID),
    .issue_rd      (bus.ISSUE_RD),
    .issue_ready   (bus.ISSUE_READY),
    .rd_busy       (bus.RD_BUSY),
    .err_underflow (bus.ERR_UNDERFLOW)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against a
// behavioural model built from plain arrays of register values and pending counts.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.A_WIDTH(5), .D_WIDTH(32), .NR(2)) bus ();

  regfile_sb #(.A_WIDTH(5), .D_WIDTH(32), .NR(2), .CNT_W(2), .DBG_IDX(10)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  logic [31:0] mreg [32];
  int          mcnt [32];
  bit          merr;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mreg[r] = '0;
      mcnt[r] = 0;
    end
    merr = 1'b0;
  endtask

  function automatic logic [31:0] m_rd(input int ra);
    if (ra == 0) return 32'h0;
    if (bus.WE3 && int'(bus.A3) == ra) return bus.WD3;
    return mreg[ra];
  endfunction

  function automatic bit m_busy(input int ra);
    if (ra == 0 || mcnt[ra] == 0) return 1'b0;
    return !(bus.WE3 && int'(bus.A3) == ra && mcnt[ra] == 1);
  endfunction

  function automatic bit m_ready();
    int rd;
    rd = int'(bus.ISSUE_RD);
    return !(rd != 0 && mcnt[rd] == 3 && !(bus.WE3 && int'(bus.A3) == rd));
  endfunction

  task automatic set_idle();
    bus.RA          = '0;
    bus.WE3         = 1'b0;
    bus.A3          = '0;
    bus.WD3         = '0;
    bus.ISSUE_VALID = 1'b0;
    bus.ISSUE_RD    = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs held before the edge.
  task automatic tick();
    logic [31:0] nreg [32];
    int          ncnt [32];
    bit          nerr;
    bit          rdy;
    int          a3;
    nreg = mreg;
    ncnt = mcnt;
    nerr = merr;
    rdy  = m_ready();
    a3   = int'(bus.A3);
    if (bus.WE3 && a3 != 0) begin
      nreg[a3] = bus.WD3;
      if (mcnt[a3] == 0) nerr = 1'b1;
      else ncnt[a3] = ncnt[a3] - 1;
    end
    if (bus.ISSUE_VALID && rdy && bus.ISSUE_RD != 0) begin
      ncnt[bus.ISSUE_RD] = ncnt[bus.ISSUE_RD] + 1;
    end
    @(posedge clk);
    mreg = nreg;
    mcnt = ncnt;
    merr = nerr;
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_state();
    bus.RA[0] = 5'd5;
    bus.RA[1] = 5'd10;
    #1;
    n_total++;
    if (bus.RD !== 64'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_rd got=%h exp=0", bus.RD);
    end
    n_total++;
    if (bus.ISSUE_READY !== 1'b1 || bus.RD_BUSY !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL reset_ready_busy got=%b/%b exp=1/00", bus.ISSUE_READY, bus.RD_BUSY);
    end
    n_total++;
    if (bus.DBG !== 32'h0 || bus.ERR_UNDERFLOW !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_dbg_err got=%h/%b exp=0/0", bus.DBG, bus.ERR_UNDERFLOW);
    end
    set_idle();
  endtask

  task automatic test_x0();
    bus.WE3 = 1'b1;
    bus.A3 = 5'd0;
    bus.WD3 = 32'hDEADBEEF;
    bus.ISSUE_VALID = 1'b1;
    bus.ISSUE_RD = 5'd0;
    #1;
    n_total++;
    if (bus.RD[0] !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL x0_bypass got=%h exp=0", bus.RD[0]);
    end
    n_total++;
    if (bus.ISSUE_READY !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL x0_issue_ready got=%b exp=1", bus.ISSUE_READY);
    end
    tick();
    set_idle();
    #1;
    n_total++;
    if (bus.RD[0] !== 32'h0 || bus.RD_BUSY[0] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL x0_after got=%h/%b exp=0/0", bus.RD[0], bus.RD_BUSY[0]);
    end
    n_total++;
    if (bus.ERR_UNDERFLOW !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL x0_no_underflow got=%b exp=0", bus.ERR_UNDERFLOW);
    end
  endtask

  task automatic test_bypass();
    bus.WE3 = 1'b1;
    bus.A3 = 5'd5;
    bus.WD3 = 32'h12345678;
    bus.RA[0] = 5'd5;
    bus.RA[1] = 5'd5;
    #1;
    n_total++;
    if (bus.RD[0] !== 32'h12345678 || bus.RD[1] !== 32'h12345678) begin
      n_bad++;
      $display("[TB] FAIL bypass_same got=%h/%h exp=12345678", bus.RD[0], bus.RD[1]);
    end
    tick();
    bus.WE3 = 1'b0;
    #1;
    n_total++;
    if (bus.RD[0] !== 32'h12345678 || bus.RD[1] !== 32'h12345678) begin
      n_bad++;
      $display("[TB] FAIL bypass_next got=%h/%h exp=12345678", bus.RD[0], bus.RD[1]);
    end
    set_idle();
  endtask

  task automatic test_raw_busy();
    bus.ISSUE_VALID = 1'b1;
    bus.ISSUE_RD = 5'd7;
    bus.RA[0] = 5'd7;
    #1;
    n_total++;
    if (bus.RD_BUSY[0] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL raw_issue_cycle got=%b exp=0", bus.RD_BUSY[0]);
    end
    tick();
    bus.ISSUE_VALID = 1'b0;
    #1;
    n_total++;
    if (bus.RD_BUSY !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL raw_busy got=%b exp=01", bus.RD_BUSY);
    end
    bus.WE3 = 1'b1;
    bus.A3 = 5'd7;
    bus.WD3 = 32'hCAFE0007;
    #1;
    n_total++;
    if (bus.RD_BUSY[0] !== 1'b0 || bus.RD[0] !== 32'hCAFE0007) begin
      n_bad++;
      $display("[TB] FAIL raw_resolve got=%b/%h exp=0/cafe0007", bus.RD_BUSY[0], bus.RD[0]);
    end
    tick();
    bus.WE3 = 1'b0;
    #1;
    n_total++;
    if (bus.RD_BUSY[0] !== 1'b0 || bus.ERR_UNDERFLOW !== merr) begin
      n_bad++;
      $display("[TB] FAIL raw_after got=%b/%b exp=0/%b", bus.RD_BUSY[0], bus.ERR_UNDERFLOW, merr);
    end
    set_idle();
  endtask

  task automatic test_saturation();
    bus.RA[0] = 5'd3;
    for (int k = 0; k < 3; k++) begin
      bus.ISSUE_VALID = 1'b1;
      bus.ISSUE_RD = 5'd3;
      #1;
      n_total++;
      if (bus.ISSUE_READY !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL sat_fill_ready k=%0d got=%b exp=1", k, bus.ISSUE_READY);
      end
      tick();
    end
    #1;
    n_total++;
    if (bus.ISSUE_READY !== 1'b0 || bus.RD_BUSY[0] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL sat_full got=%b/%b exp=0/1", bus.ISSUE_READY, bus.RD_BUSY[0]);
    end
    tick();
    bus.WE3 = 1'b1;
    bus.A3 = 5'd3;
    bus.WD3 = 32'h33;
    #1;
    n_total++;
    if (bus.ISSUE_READY !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL sat_issue_with_wb got=%b exp=1", bus.ISSUE_READY);
    end
    tick();
    bus.WE3 = 1'b0;
    bus.ISSUE_VALID = 1'b0;
    #1;
    n_total++;
    if (bus.ISSUE_READY !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL sat_still_full got=%b exp=0", bus.ISSUE_READY);
    end
    for (int k = 0; k < 3; k++) begin
      bus.WE3 = 1'b1;
      bus.WD3 = 32'h300 + 32'(k);
      tick();
      bus.WE3 = 1'b0;
      #1;
      n_total++;
      if (bus.ISSUE_READY !== 1'b1 || bus.RD_BUSY[0] !== (k != 2)) begin
        n_bad++;
        $display("[TB] FAIL sat_drain k=%0d got=%b/%b exp=1/%b", k, bus.ISSUE_READY, bus.RD_BUSY[0], k != 2);
      end
    end
    n_total++;
    if (bus.ERR_UNDERFLOW !== 1'b0 || bus.RD[0] !== 32'h302) begin
      n_bad++;
      $display("[TB] FAIL sat_end got=%b/%h exp=0/302", bus.ERR_UNDERFLOW, bus.RD[0]);
    end
    set_idle();
  endtask

  task automatic test_underflow();
    #1;
    n_total++;
    if (bus.ERR_UNDERFLOW !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL uf_before got=%b exp=0", bus.ERR_UNDERFLOW);
    end
    bus.WE3 = 1'b1;
    bus.A3 = 5'd9;
    bus.WD3 = 32'h0000_0999;
    tick();
    set_idle();
    bus.RA[0] = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if (bus.ERR_UNDERFLOW !== 1'b1 || bus.RD[0] !== 32'h999 || bus.RD_BUSY[0] !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL uf_sticky k=%0d got=%b/%h/%b exp=1/999/0", k, bus.ERR_UNDERFLOW, bus.RD[0], bus.RD_BUSY[0]);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_dbg();
    bus.WE3 = 1'b1;
    bus.A3 = 5'd10;
    bus.WD3 = 32'd42;
    #1;
    n_total++;
    if (bus.DBG !== 32'd42) begin
      n_bad++;
      $display("[TB] FAIL dbg_bypass got=%h exp=2a", bus.DBG);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.A3 = 5'd11;
      bus.WD3 = $urandom;
      #1;
      n_total++;
      if (bus.DBG !== 32'd42) begin
        n_bad++;
        $display("[TB] FAIL dbg_hold k=%0d got=%h exp=2a", k, bus.DBG);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset();
    bus.ISSUE_VALID = 1'b1;
    bus.ISSUE_RD = 5'd4;
    tick();
    tick();
    bus.ISSUE_VALID = 1'b0;
    bus.RA[0] = 5'd4;
    bus.RA[1] = 5'd10;
    #1;
    n_total++;
    if (bus.RD_BUSY[0] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rst_pre_busy got=%b exp=1", bus.RD_BUSY[0]);
    end
    bus.WE3 = 1'b1;
    bus.A3 = 5'd10;
    bus.WD3 = 32'h5555AAAA;
    bus.ISSUE_RD = 5'd4;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (bus.RD !== 64'h0 || bus.DBG !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL rst_mid_data got=%h/%h exp=0/0", bus.RD, bus.DBG);
    end
    n_total++;
    if (bus.RD_BUSY !== 2'b00 || bus.ISSUE_READY !== 1'b1 || bus.ERR_UNDERFLOW !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL rst_mid_status got=%b/%b/%b exp=00/1/0", bus.RD_BUSY, bus.ISSUE_READY, bus.ERR_UNDERFLOW);
    end
    @(posedge clk);
    #1;
    set_idle();
    bus.RA[0] = 5'd4;
    bus.RA[1] = 5'd10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.RD_BUSY !== 2'b00 || bus.RD[1] !== 32'h0 || bus.DBG !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL rst_after got=%b/%h/%h exp=00/0/0", bus.RD_BUSY, bus.RD[1], bus.DBG);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.RA[0]       = 5'($urandom_range(0, 11));
      bus.RA[1]       = 5'($urandom_range(0, 11));
      bus.WE3         = ($urandom_range(0, 9) < 4);
      bus.A3          = 5'($urandom_range(0, 11));
      bus.WD3         = $urandom;
      bus.ISSUE_VALID = ($urandom_range(0, 1) == 1);
      bus.ISSUE_RD    = 5'($urandom_range(0, 11));
      #1;
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if (bus.RD[i] !== m_rd(int'(bus.RA[i])) || bus.RD_BUSY[i] !== m_busy(int'(bus.RA[i]))) begin
          n_bad++;
          $display("[TB] FAIL rand_port c=%0d i=%0d got=%h/%b exp=%h/%b", c, i, bus.RD[i], bus.RD_BUSY[i],
                   m_rd(int'(bus.RA[i])), m_busy(int'(bus.RA[i])));
        end
      end
      n_total++;
      if (bus.ISSUE_READY !== m_ready() || bus.DBG !== m_rd(10) || bus.ERR_UNDERFLOW !== merr) begin
        n_bad++;
        $display("[TB] FAIL rand_status c=%0d got=%b/%h/%b exp=%b/%h/%b", c, bus.ISSUE_READY, bus.DBG,
                 bus.ERR_UNDERFLOW, m_ready(), m_rd(10), merr);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset_state();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_x0();
    test_bypass();
    test_raw_busy();
    do_reset();
    test_saturation();
    do_reset();
    test_underflow();
    test_dbg();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
